bitwise_unit_mc: RTL and testbench



---
 rtl/bitwise_unit_mc.sv | 122 ++++++++++++
 tb/tb_bitwise_unit_mc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bitwise_unit_mc.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR), SLICE bits per clock.
// Start/done handshake; result and zero flag update only on completion.
module bitwise_unit_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    localparam int unsigned NS   = WIDTH / SLICE;
    localparam int unsigned CntW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               accept;

    function automatic logic [SLICE-1:0] slice_op(input logic [1:0] op,
                                                  input logic [SLICE-1:0] x,
                                                  input logic [SLICE-1:0] y);
        logic [SLICE-1:0] r;
        unique case (op)
            2'b00: r = x & y;
            2'b01: r = x | y;
            2'b10: r = x ^ y;
            2'b11: r = ~(x | y);
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (cnt_q == LastCnt) state_d = StDone;
            StDone:  state_d = start_i ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // New operations are accepted from IDLE and from DONE (back-to-back).
    assign accept = start_i && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (accept) begin
            a_d    = a_i;
            b_d    = b_i;
            op_d   = op_i;
            work_d = '0;
            cnt_d  = '0;
        end else if (state_q == StRun) begin
            for (int unsigned i = 0; i < NS; i++) begin
                if (cnt_q == CntW'(i)) begin
                    work_d[i*SLICE +: SLICE] = slice_op(op_q, a_q[i*SLICE +: SLICE],
                                                        b_q[i*SLICE +: SLICE]);
                end
            end
            if (cnt_q == LastCnt) begin
                result_d = work_d;
                zero_d   = (work_d == '0);
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_comb begin
        busy_o = (state_q == StRun);
        done_o = (state_q == StDone);
    end

    assign result_o = result_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_bitwise_unit_mc.sv
// Directed, table-driven bench for bitwise_unit_mc: default, 64/16 and 32/32 configurations.
module tb_bitwise_unit_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start = 3'b000;
    logic [1:0]  op = 2'b00;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    logic        busy0, done0, zero0;
    logic [31:0] res0;
    logic        busy1, done1, zero1;
    logic [63:0] res1;
    logic        busy2, done2, zero2;
    logic [31:0] res2;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bitwise_unit_mc #(.WIDTH(32), .SLICE(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .op_i(op), .a_i(a[31:0]), .b_i(b[31:0]),
        .busy_o(busy0), .done_o(done0), .result_o(res0), .zero_o(zero0)
    );

    bitwise_unit_mc #(.WIDTH(64), .SLICE(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .op_i(op), .a_i(a), .b_i(b),
        .busy_o(busy1), .done_o(done1), .result_o(res1), .zero_o(zero1)
    );

    bitwise_unit_mc #(.WIDTH(32), .SLICE(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start[2]), .op_i(op), .a_i(a[31:0]), .b_i(b[31:0]),
        .busy_o(busy2), .done_o(done2), .result_o(res2), .zero_o(zero2)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t tbl[7];

    function automatic logic get_busy(input int w);
        return (w == 0) ? busy0 : (w == 1) ? busy1 : busy2;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 0) ? done0 : (w == 1) ? done1 : done2;
    endfunction

    function automatic logic get_zero(input int w);
        return (w == 0) ? zero0 : (w == 1) ? zero1 : zero2;
    endfunction

    function automatic logic [63:0] get_res(input int w);
        return (w == 0) ? {32'h0, res0} : (w == 1) ? res1 : {32'h0, res2};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic issue(input int w, input logic [1:0] o, input logic [63:0] x,
                         input logic [63:0] y);
        op = o;
        a = x;
        b = y;
        start = 3'b000;
        start[w] = 1'b1;
        @(negedge clk);
        start = 3'b000;
    endtask

    // Counts busy cycles until done, bounded; leaves us at the negedge where done is high.
    task automatic wait_done(input int w, input int exp_busy, input logic [63:0] exp_res,
                             input logic exp_zero, input string name);
        int busy_cnt = 0;
        int cyc = 0;
        while (get_done(w) !== 1'b1 && cyc < 30) begin
            if (get_busy(w) === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check({name, " done"}, {63'h0, get_done(w)}, 64'h1);
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({name, " busy_at_done"}, {63'h0, get_busy(w)}, 64'h0);
        check({name, " result"}, get_res(w), exp_res);
        check({name, " zero"}, {63'h0, get_zero(w)}, {63'h0, exp_zero});
    endtask

    initial begin
        tbl[0] = '{2'b00, 32'h22220225, 32'hC2420423, 32'h02020021, 1'b0};
        tbl[1] = '{2'b01, 32'h22220225, 32'hC2420423, 32'hE2620627, 1'b0};
        tbl[2] = '{2'b10, 32'h22220225, 32'hC2420423, 32'hE0600606, 1'b0};
        tbl[3] = '{2'b11, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1};
        tbl[4] = '{2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        tbl[5] = '{2'b10, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b1};
        tbl[6] = '{2'b01, 32'h0000000F, 32'hF0000000, 32'hF000000F, 1'b0};

        // Reset then idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset result", {32'h0, res0}, 64'h0);
        check("reset zero", {63'h0, zero0}, 64'h1);
        check("reset busy", {63'h0, busy0}, 64'h0);
        check("reset done", {63'h0, done0}, 64'h0);

        // Isolated AND with one-cycle start pulse
        issue(0, 2'b00, 64'hFFFFFFFF, 64'h40A00400);
        wait_done(0, 4, 64'h40A00400, 1'b0, "and");
        @(negedge clk);
        check("and done_pulse", {63'h0, done0}, 64'h0);
        check("and hold", {32'h0, res0}, 64'h40A00400);
        repeat (2) @(negedge clk);

        // Back-to-back chain: each next op is started in the DONE cycle
        issue(0, tbl[0].op, {32'h0, tbl[0].a}, {32'h0, tbl[0].b});
        for (int i = 0; i < 7; i++) begin
            wait_done(0, 4, {32'h0, tbl[i].res}, tbl[i].zero, $sformatf("vec%0d", i));
            if (i < 6) issue(0, tbl[i+1].op, {32'h0, tbl[i+1].a}, {32'h0, tbl[i+1].b});
        end
        @(negedge clk);
        check("chain idle", {62'h0, busy0, done0}, 64'h0);

        // Start and operand changes during RUN are ignored
        issue(0, 2'b11, 64'hFFFFFFFF, 64'h0);
        start[0] = 1'b1;
        a = 64'h0;
        op = 2'b00;
        @(negedge clk);
        start = 3'b000;
        wait_done(0, 3, 64'h0, 1'b1, "nor_ignore");
        @(negedge clk);
        check("nor_ignore idle", {63'h0, busy0}, 64'h0);

        // Parameter sweep
        issue(1, 2'b10, 64'h0123456789ABCDEF, 64'hFFFFFFFF00000000);
        wait_done(1, 4, 64'hFEDCBA9889ABCDEF, 1'b0, "w64");
        @(negedge clk);
        issue(2, 2'b00, 64'hFFFFFFFF, 64'h40A00400);
        wait_done(2, 1, 64'h40A00400, 1'b0, "w32s32");
        @(negedge clk);

        // Reset mid-run: make result nonzero first
        issue(0, 2'b01, 64'h0000000F, 64'hF0000000);
        wait_done(0, 4, 64'hF000000F, 1'b0, "pre_rst");
        @(negedge clk);
        issue(0, 2'b00, 64'hFFFFFFFF, 64'hFFFFFFFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst busy", {63'h0, busy0}, 64'h0);
        check("midrst result", {32'h0, res0}, 64'h0);
        check("midrst zero", {63'h0, zero0}, 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (done0 === 1'b1 || busy0 === 1'b1) seen++;
            end
            check("midrst no_done", 64'(seen), 64'h0);
        end
        check("midrst result_after", {32'h0, res0}, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
